ocl_axil_reg_bridge: RTL
========================

Name: ocl_axil_reg_bridge

Overview:
- AXI4-Lite slave front-end between the shell's OCL register slice (BAR0) and the Ising machine register file.
- Terminates all AXI-Lite handshakes. Presents the register file with single-cycle write strobes and a read request/acknowledge pair.
- Returns SLVERR on read timeout so a stalled backend cannot hang the host.
- Replaces the ad-hoc write/read handshake glue in the CL top.

Parameters:
- ADDR_W, 32, AXI-Lite and register address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)
- RD_TIMEOUT, 256, cycles to wait for reg_rd_valid before returning SLVERR (minimum 2)

Ports:
- clk  in  1  sole clock, the main CL clock
- rst  in  1  reset, asynchronous assert, active-high
- s_awvalid in 1 / s_awaddr in ADDR_W / s_awready out 1  write address channel
- s_wvalid in 1 / s_wdata in DATA_W / s_wstrb in DATA_W/8 / s_wready out 1  write data channel
- s_bvalid out 1 / s_bresp out 2 / s_bready in 1  write response channel
- s_arvalid in 1 / s_araddr in ADDR_W / s_arready out 1  read address channel
- s_rvalid out 1 / s_rdata out DATA_W / s_rresp out 2 / s_rready in 1  read data channel
- reg_wr_en  out  1  one-cycle write strobe to the register file
- reg_wr_addr  out  ADDR_W  write address, valid with reg_wr_en
- reg_wr_data  out  DATA_W  write data, valid with reg_wr_en
- reg_wr_strb  out  DATA_W/8  byte enables, valid with reg_wr_en
- reg_rd_en  out  1  one-cycle read request
- reg_rd_addr  out  ADDR_W  read address, held from reg_rd_en until the read completes
- reg_rd_valid  in  1  read data valid from the backend; any latency of 1 or more cycles
- reg_rd_data  in  DATA_W  read data, sampled when reg_rd_valid is high

Behaviour:
- Reset: all outputs are 0, except s_awready, s_wready and s_arready, which are 1. Both FSMs go to IDLE and the timeout counter clears. Reset asserted mid-transaction abandons the transaction with no response.
- Write channel:
  - AW and W are captured independently, in either order or in the same cycle.
  - s_awready is high only while no address is held and the FSM is in W_IDLE; s_wready is the same for data.
  - Once both are held: reg_wr_en pulses exactly one cycle on the next edge, with the captured addr, data and strb.
  - On the following cycle s_bvalid=1 and s_bresp=2'b00. s_bvalid stays high until s_bready is high.
  - Response is accepted on the clock edge where s_bvalid and s_bready are both high. The held flags clear on that edge and both readies rise again the next cycle.
  - Write FSM: W_IDLE (collecting AW/W) -> W_ISSUE (1 cycle, strobe) -> W_RESP (bvalid) -> W_IDLE.
  - Maximum throughput: one write per 3 cycles.
- Read channel:
  - Read FSM: R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: s_arready=1. On the s_arvalid handshake, latch s_araddr into reg_rd_addr, pulse reg_rd_en for one cycle, clear the counter, and go to R_WAIT.
  - R_WAIT: counter increments each cycle.
    - If reg_rd_valid is high: latch reg_rd_data into s_rdata, set s_rresp=00, go to R_RESP.
    - Else if counter reaches RD_TIMEOUT-1: set s_rdata=32'hDEAD_BEEF (truncated/zero-extended to DATA_W) and s_rresp=2'b10 (SLVERR), go to R_RESP.
    - reg_rd_valid in the same cycle as the timeout wins: data is returned with OKAY.
  - R_RESP: s_rvalid=1. s_rdata and s_rresp are stable until the handshake, then the FSM returns to R_IDLE.
  - reg_rd_valid outside R_WAIT, including late data after a timeout, is ignored and dropped.
- Read and write channels run concurrently and independently. A reg_wr_en and a reg_rd_en may occur in the same cycle; ordering between the two is the backend's responsibility.
- No address decoding and no DECERR: every address is forwarded unchanged.
- The counter is clog2(RD_TIMEOUT) bits wide and never wraps; it saturates and is held in R_WAIT only.

Test Plan:
- Reset then idle: all valids and enables are 0; awready, wready and arready are 1. Assert rst mid-R_WAIT: the FSM returns to R_IDLE and rvalid stays 0.
- AW=0x10 and W=0xCAFE0001 with strb=0xF in the same cycle: reg_wr_en high for exactly 1 cycle with those values; bvalid the next cycle with bresp=0. Hold bready low 5 cycles: bvalid stays high and awready stays 0 throughout.
- W=0x5 presented 4 cycles before AW=0x24: wready drops after W capture; strobe carries addr 0x24, data 0x5. Repeat with AW first: identical strobe.
- Read addr 0x08 with the backend returning 0x1234ABCD 3 cycles after reg_rd_en: rvalid with rdata=0x1234ABCD, rresp=0. rready held low 4 cycles: data stable, arready stays 0.
- Read with no reg_rd_valid: rvalid after RD_TIMEOUT cycles with rresp=2'b10 and rdata=0xDEADBEEF. A late reg_rd_valid is ignored, and the next read returns its own data correctly.
- Back-to-back interleave: a write to 0x30 concurrent with a read of 0x30 completes both responses; 100 random-order AW/W/AR sequences with random ready backpressure match a reference model with no lost or duplicated strobes.

Source files
------------

// File: rtl/ocl_axil_reg_bridge.sv
// AXI4-Lite slave bridge from the OCL BAR0 register slice to the Ising machine register file.
// Independent write and read FSMs; a read the backend never answers returns SLVERR.
module ocl_axil_reg_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                s_awvalid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awready,

    input  logic                s_wvalid,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wready,

    output logic                s_bvalid,
    output logic [1:0]          s_bresp,
    input  logic                s_bready,

    input  logic                s_arvalid,
    input  logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arready,

    output logic                s_rvalid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    input  logic                s_rready,

    output logic                reg_wr_en,
    output logic [ADDR_W-1:0]   reg_wr_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic [DATA_W/8-1:0] reg_wr_strb,

    output logic                reg_rd_en,
    output logic [ADDR_W-1:0]   reg_rd_addr,
    input  logic                reg_rd_valid,
    input  logic [DATA_W-1:0]   reg_rd_data
);

    localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(RD_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ISSUE,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    wr_state_t        wr_state;
    rd_state_t        rd_state;
    logic             aw_held;
    logic             w_held;
    logic             aw_take;
    logic             w_take;
    logic [CNT_W-1:0] rd_cnt;

    // Readies come straight from flops so they never depend combinationally on a valid.
    assign s_awready = (wr_state == W_IDLE) && !aw_held;
    assign s_wready  = (wr_state == W_IDLE) && !w_held;
    assign s_arready = (rd_state == R_IDLE);
    assign aw_take   = s_awvalid && s_awready;
    assign w_take    = s_wvalid && s_wready;
    assign s_bresp   = 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state    <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
            reg_wr_strb <= '0;
            s_bvalid    <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            case (wr_state)
                W_IDLE: begin
                    if (aw_take) begin
                        aw_held     <= 1'b1;
                        reg_wr_addr <= s_awaddr;
                    end
                    if (w_take) begin
                        w_held      <= 1'b1;
                        reg_wr_data <= s_wdata;
                        reg_wr_strb <= s_wstrb;
                    end
                    if ((aw_held || aw_take) && (w_held || w_take)) begin
                        reg_wr_en <= 1'b1;
                        wr_state  <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    s_bvalid <= 1'b1;
                    wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Backend data landing in the same cycle as the timeout still wins over SLVERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state    <= R_IDLE;
            reg_rd_en   <= 1'b0;
            reg_rd_addr <= '0;
            rd_cnt      <= '0;
            s_rvalid    <= 1'b0;
            s_rdata     <= '0;
            s_rresp     <= 2'b00;
        end else begin
            reg_rd_en <= 1'b0;
            case (rd_state)
                R_IDLE: begin
                    if (s_arvalid) begin
                        reg_rd_addr <= s_araddr;
                        reg_rd_en   <= 1'b1;
                        rd_cnt      <= '0;
                        rd_state    <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (reg_rd_valid) begin
                        s_rdata  <= reg_rd_data;
                        s_rresp  <= 2'b00;
                        s_rvalid <= 1'b1;
                        rd_state <= R_RESP;
                    end else if (rd_cnt == CNT_LAST) begin
                        s_rdata  <= TIMEOUT_DATA;
                        s_rresp  <= 2'b10;
                        s_rvalid <= 1'b1;
                        rd_state <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule
